// File: rtl/dmem_pkg.sv
// Shared types, constants and the address-window check for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic [31:0] IO_PAGE_BASE = 32'hFFFFFC00;
  localparam int unsigned DEPTH_LOG2_DEF = 14;

  // Word aligned and inside the RAM window; the IO page lies above any legal window.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth_log2);
    return (addr[1:0] == 2'b00) && ((addr >> (depth_log2 + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports 0/1 plus the memory-side bus of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DEPTH_LOG2 = dmem_pkg::DEPTH_LOG2_DEF,
  parameter int unsigned DATA_W     = 32
);
  logic                  req0, we0, ack0, err0;
  logic [31:0]           addr0;
  logic [DATA_W-1:0]     wdata0, rdata0;
  logic                  req1, we1, ack1, err1;
  logic [31:0]           addr1;
  logic [DATA_W-1:0]     wdata1, rdata1;
  logic                  mem_en, mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata, mem_rdata;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, err0, rdata0, ack1, err1, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, err0, rdata0, ack1, err1, rdata1, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 && req1) ? ~last_grant : req1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one BRAM between two ports, 3 cycles per access.
// Optional statistics counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned DATA_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           busy,
  output logic           grant_id
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    grant_cnt0,
  output logic [31:0]    grant_cnt1,
  output logic [15:0]    err_cnt
`endif
);

  state_e                r_state, w_state_next;
  logic                  r_last_grant, r_grant_id, r_we, r_ok;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata, w_rdata;
  logic                  w_gnt_valid, w_gnt_id;
  logic [31:0]           w_sel_addr;

  rr_arb2 u_rr_arb2 (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_gnt_valid) w_state_next = StIssue;
      StIssue: w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_sel_addr = w_gnt_id ? bus.addr1 : bus.addr0;

  // Winner's request is captured once; later changes on either port are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_we         <= 1'b0;
      r_ok         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (r_state == StIdle && w_gnt_valid) begin
      r_last_grant <= w_gnt_id;
      r_grant_id   <= w_gnt_id;
      r_we         <= w_gnt_id ? bus.we1 : bus.we0;
      r_ok         <= addr_ok(w_sel_addr, DEPTH_LOG2);
      r_addr       <= w_sel_addr[DEPTH_LOG2+1:2];
      r_wdata      <= w_gnt_id ? bus.wdata1 : bus.wdata0;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ack0      = 1'b0;
    bus.err0      = 1'b0;
    bus.rdata0    = '0;
    bus.ack1      = 1'b0;
    bus.err1      = 1'b0;
    bus.rdata1    = '0;
    w_rdata       = (r_ok && !r_we) ? bus.mem_rdata : '0;
    unique case (r_state)
      StIssue: begin
        bus.mem_en    = r_ok;
        bus.mem_we    = r_ok & r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
      end
      StResp: begin
        if (r_grant_id) begin
          bus.ack1   = 1'b1;
          bus.err1   = ~r_ok;
          bus.rdata1 = w_rdata;
        end else begin
          bus.ack0   = 1'b1;
          bus.err0   = ~r_ok;
          bus.rdata0 = w_rdata;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != StIdle);
  assign grant_id = r_grant_id;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_grant_cnt0, r_grant_cnt1;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_err_cnt    <= '0;
    end else if (r_state == StResp) begin
      if (r_grant_id) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      else            r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (!r_ok)      r_err_cnt    <= r_err_cnt + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign err_cnt    = r_err_cnt;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port synchronous data memory (word-addressed BRAM, 1-cycle read latency).
- Shares the memory between the CPU load/store path (port 0) and the UART program/debug loader (port 1).
- Round-robin arbitration; every access runs a fixed 3-cycle request/ack handshake.
- Addresses outside the RAM window, including the 0xFFFFFCxx IO page, and misaligned addresses are rejected with an error ack. The memory is never touched for these.

Parameters:
- DEPTH_LOG2, 14, log2 of the memory depth in 32-bit words. RAM window is byte addresses 0 to 2^(DEPTH_LOG2+2)-1.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = store).
- addr0  in  32  port 0 byte address.
- wdata0  in  DATA_W  port 0 store data.
- ack0  out  1  port 0 completion pulse, 1 cycle.
- rdata0  out  DATA_W  port 0 load data; valid only while ack0 = 1.
- err0  out  1  port 0 address error; valid only while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  DEPTH_LOG2  word address = addr[DEPTH_LOG2+1:2].
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  1  port owning the current or last access.

Behaviour:
- States and transitions:
  - IDLE: no request -> stay. Any request -> ISSUE.
  - ISSUE -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Arbitration in IDLE:
  - Only one request -> that port wins.
  - Both requesting -> the port other than last_grant wins.
  - On entry to ISSUE, latch the winner's id, we, addr, wdata and the address check result. Set last_grant = winner.
- Address check:
  - ok = (addr[1:0] == 0) and (addr[31:DEPTH_LOG2+2] == 0).
- ISSUE cycle:
  - mem_en = ok.
  - mem_we = ok and latched we.
  - mem_addr and mem_wdata come from the latches.
  - All mem outputs are 0 outside ISSUE.
- RESP cycle:
  - ack of the winner = 1.
  - err = not ok.
  - rdata = mem_rdata if (ok and not we), else 0.
  - The other port's ack/rdata/err stay 0.
- Timing and throughput:
  - Fixed latency: request sampled at edge t -> mem access in cycle t+1 -> ack in cycle t+2.
  - One access per 3 cycles.
  - A request still high in the IDLE cycle after its ack is treated as a new access. Requesters must drop req after ack unless issuing back-to-back.
- Changes to the losing port's inputs while it waits are harmless; only values at grant time are used.
- A winner deasserting req during ISSUE/RESP does not abort the access; it completes and acks.
- Reset (any state, including mid-access):
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - All outputs 0.
  - An in-flight access is dropped with no ack. A write issued in the ISSUE cycle of the reset edge may still land in memory.
- grant_id resets to 0, updates on entry to ISSUE, and holds otherwise.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 (32-bit each) and err_cnt (16-bit).
  - Each grant counter increments on its port's ack.
  - err_cnt increments on any ack with err = 1.
  - Counters wrap silently and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package dmem_pkg:
  - State encoding: IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2.
  - IO page base 32'hFFFFFC00.
  - Default DEPTH_LOG2.
- One natural sub-module: rr_arb2, a 2-requester round-robin picker. Pure combinational, with inputs req0, req1, last_grant and outputs gnt_valid, gnt_id.
- Latches and the FSM stay in dmem_arbiter.

Test Plan:
- Port 0 store: addr0 = 0x10, wdata0 = 0xDEADBEEF, then load from 0x10 -> store: mem_we = 1, mem_addr = 4 in ISSUE; ack0 two cycles after req0 sampled. Load: ack0 with rdata0 = 0xDEADBEEF, err0 = 0.
- req0 and req1 both held high continuously after reset -> grant order 0,1,0,1; acks spaced 3 cycles apart; grant_id toggles.
- Port 1 load addr1 = 0xFFFFFC60 -> mem_en stays 0; ack1 = 1, err1 = 1, rdata1 = 0. Repeat with addr1 = 0x6 (misaligned) -> same result.
- Reset asserted during ISSUE of a port 0 load -> no ack0; next cycle busy = 0 and all outputs 0. Following tie -> port 0 wins.
- Port 1 deasserts req1 during its ISSUE cycle -> access still completes; ack1 pulses once.
- With DMEM_ARB_STATS_EN: 3 port 0 acks, 2 port 1 acks, 1 error -> grant_cnt0 = 3, grant_cnt1 = 2, err_cnt = 1; all read 0 after rst.
